// File: rtl/routing_table_ctx_pkg.sv
// Shared definitions for the routing table slice: the sequencing FSM state
// encoding and the width helpers used to size context selects and counters.
package routing_table_ctx_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        PASS   = 2'd1,
        RELOAD = 2'd2
    } rt_state_e;

    // Ceiling log2; returns 0 for a value of 1.
    function automatic int rt_clog2(input int value);
        int result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Width of a context select; never narrower than one bit.
    function automatic int rt_ctx_width(input int num_ctx);
        return (num_ctx > 1) ? rt_clog2(num_ctx) : 1;
    endfunction

endpackage

// File: rtl/rt_dp_ram.sv
// Table storage: one write port, two combinational read ports. Reads see the
// pre-edge contents, so a read and a write to the same word in one cycle
// returns the old value once the reader registers it.
module rt_dp_ram #(
    parameter int WIDTH   = 9,
    parameter int LOG_DEP = 10
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [LOG_DEP-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [LOG_DEP-1:0] rd_addr_a,
    input  logic [LOG_DEP-1:0] rd_addr_b,
    output logic [WIDTH-1:0]   rd_data_a,
    output logic [WIDTH-1:0]   rd_data_b
);

    logic [WIDTH-1:0] mem [0:(2**LOG_DEP)-1];

    // Single write port; contents are not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/routing_table_ctx.sv
// Multi-context next-hop table. The configuration stream first fills every
// context (LOAD), then passes through downstream (PASS) until a single
// context is rewritten on request (RELOAD). Two lookup ports read the lower
// and upper half of the selected context.
// Build option: define RT_OUT_REG_EN for a second output register stage.
//
//   state  | meaning
//   LOAD   | filling all contexts in order after reset
//   PASS   | table complete, config stream forwarded downstream
//   RELOAD | rewriting one context, stream consumed
module routing_table_ctx
    import routing_table_ctx_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NH_WIDTH   = 9,
    parameter int NUM_CTX    = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [15:0]                         ram_config_in,
    input  logic                                ram_config_in_valid,
    output logic [15:0]                         ram_config_out,
    output logic                                ram_config_out_valid,
    input  logic                                reload_req,
    input  logic [rt_ctx_width(NUM_CTX)-1:0]    reload_ctx,
    output logic                                reload_busy,
    input  logic [rt_ctx_width(NUM_CTX)-1:0]    ctx_sel,
    input  logic                                lookup_valid,
    input  logic [ADDR_WIDTH-1:0]               dest_ina,
    input  logic [ADDR_WIDTH-1:0]               dest_inb,
    output logic [NH_WIDTH-1:0]                 nexthop_outa,
    output logic [NH_WIDTH-1:0]                 nexthop_outb,
    output logic                                nexthop_valid
);

    localparam int LOG_CTX = rt_clog2(NUM_CTX);
    localparam int CTX_W   = rt_ctx_width(NUM_CTX);
    localparam int WPC_W   = ADDR_WIDTH + 1;
    localparam int IDX_W   = CTX_W + WPC_W;
    localparam int CNT_W   = LOG_CTX + ADDR_WIDTH + 2;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(NUM_CTX * (2 ** WPC_W) - 1);

    rt_state_e          state_q, state_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [WPC_W-1:0]   rl_cnt_q, rl_cnt_d;
    logic [CTX_W-1:0]   rl_ctx_q, rl_ctx_d;
    logic [NUM_CTX-1:0] ctx_ok_q, ctx_ok_d;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [CTX_W-1:0]   load_ctx;
    logic [NH_WIDTH-1:0] rd_a, rd_b;
    logic [NH_WIDTH-1:0] nh_a_q, nh_b_q;
    logic                nh_v_q;

    assign load_ctx       = load_cnt_q[WPC_W +: CTX_W];
    assign ram_config_out = ram_config_in;

    // Sequencer state, word counters and per-context completion flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            rl_cnt_q   <= '0;
            rl_ctx_q   <= '0;
            ctx_ok_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            rl_cnt_q   <= rl_cnt_d;
            rl_ctx_q   <= rl_ctx_d;
            ctx_ok_q   <= ctx_ok_d;
        end
    end

    // Next-state, table write steering and stream forwarding.
    always_comb begin
        state_d              = state_q;
        load_cnt_d           = load_cnt_q;
        rl_cnt_d             = rl_cnt_q;
        rl_ctx_d             = rl_ctx_q;
        ctx_ok_d             = ctx_ok_q;
        wr_en                = 1'b0;
        wr_addr              = '0;
        reload_busy          = 1'b0;
        ram_config_out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                reload_busy = 1'b1;
                if (ram_config_in_valid) begin
                    wr_en      = 1'b1;
                    wr_addr    = load_cnt_q[IDX_W-1:0];
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (&load_cnt_q[WPC_W-1:0]) begin
                        ctx_ok_d[load_ctx] = 1'b1;
                    end
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d = PASS;
                    end
                end
            end
            PASS: begin
                // A word coinciding with the request still goes downstream.
                ram_config_out_valid = ram_config_in_valid;
                if (reload_req) begin
                    rl_ctx_d             = reload_ctx;
                    ctx_ok_d[reload_ctx] = 1'b0;
                    rl_cnt_d             = '0;
                    state_d              = RELOAD;
                end
            end
            RELOAD: begin
                reload_busy = 1'b1;
                if (ram_config_in_valid) begin
                    wr_en    = 1'b1;
                    wr_addr  = {rl_ctx_q, rl_cnt_q};
                    rl_cnt_d = rl_cnt_q + 1'b1;
                    if (&rl_cnt_q) begin
                        ctx_ok_d[rl_ctx_q] = 1'b1;
                        state_d            = PASS;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    rt_dp_ram #(
        .WIDTH   (NH_WIDTH),
        .LOG_DEP (IDX_W)
    ) u_ram (
        .clock     (clock),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (ram_config_in[NH_WIDTH-1:0]),
        .rd_addr_a ({ctx_sel, 1'b0, dest_ina}),
        .rd_addr_b ({ctx_sel, 1'b1, dest_inb}),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b)
    );

    // First lookup stage; validity reflects the context state at request time.
    always_ff @(posedge clock) begin
        if (reset) begin
            nh_a_q <= '0;
            nh_b_q <= '0;
            nh_v_q <= 1'b0;
        end else if (enable) begin
            nh_v_q <= lookup_valid & ctx_ok_q[ctx_sel];
            if (lookup_valid) begin
                nh_a_q <= rd_a;
                nh_b_q <= rd_b;
            end
        end
    end

`ifdef RT_OUT_REG_EN
    logic [NH_WIDTH-1:0] nh_a_q2, nh_b_q2;
    logic                nh_v_q2;

    // Optional retiming stage, held together with the first by enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            nh_a_q2 <= '0;
            nh_b_q2 <= '0;
            nh_v_q2 <= 1'b0;
        end else if (enable) begin
            nh_a_q2 <= nh_a_q;
            nh_b_q2 <= nh_b_q;
            nh_v_q2 <= nh_v_q;
        end
    end

    assign nexthop_outa  = nh_a_q2;
    assign nexthop_outb  = nh_b_q2;
    assign nexthop_valid = nh_v_q2;
`else
    assign nexthop_outa  = nh_a_q;
    assign nexthop_outb  = nh_b_q;
    assign nexthop_valid = nh_v_q;
`endif

endmodule

// File: tb/tb_routing_table_ctx.sv
// Directed bench for routing_table_ctx at ADDR_WIDTH=3, NH_WIDTH=9, NUM_CTX=2.
// Inputs change and outputs are sampled just after the falling edge.
module tb_routing_table_ctx;

    localparam int AW = 3;
    localparam int NW = 9;
    localparam int NC = 2;
`ifdef RT_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [15:0]   ram_config_in;
    logic          ram_config_in_valid;
    logic [15:0]   ram_config_out;
    logic          ram_config_out_valid;
    logic          reload_req;
    logic [0:0]    reload_ctx;
    logic          reload_busy;
    logic [0:0]    ctx_sel;
    logic          lookup_valid;
    logic [AW-1:0] dest_ina;
    logic [AW-1:0] dest_inb;
    logic [NW-1:0] nexthop_outa;
    logic [NW-1:0] nexthop_outb;
    logic          nexthop_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [0:0]    ctx;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [NW-1:0] ea;
        logic [NW-1:0] eb;
        logic          ev;
    } vec_t;

    vec_t vecs [6];

    routing_table_ctx #(
        .ADDR_WIDTH (AW),
        .NH_WIDTH   (NW),
        .NUM_CTX    (NC)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .enable               (enable),
        .ram_config_in        (ram_config_in),
        .ram_config_in_valid  (ram_config_in_valid),
        .ram_config_out       (ram_config_out),
        .ram_config_out_valid (ram_config_out_valid),
        .reload_req           (reload_req),
        .reload_ctx           (reload_ctx),
        .reload_busy          (reload_busy),
        .ctx_sel              (ctx_sel),
        .lookup_valid         (lookup_valid),
        .dest_ina             (dest_ina),
        .dest_inb             (dest_inb),
        .nexthop_outa         (nexthop_outa),
        .nexthop_outb         (nexthop_outb),
        .nexthop_valid        (nexthop_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send_word(input logic [15:0] v);
        ram_config_in       = v;
        ram_config_in_valid = 1'b1;
        tick();
        ram_config_in_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [0:0] c, input logic [AW-1:0] a, input logic [AW-1:0] b);
        ctx_sel      = c;
        dest_ina     = a;
        dest_inb     = b;
        lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic check_lookup(input string name, input logic [0:0] c, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, input logic [NW-1:0] ea,
                                input logic [NW-1:0] eb, input logic ev);
        do_lookup(c, a, b);
        check({name, "_outa"}, 32'(nexthop_outa), 32'(ea));
        check({name, "_outb"}, 32'(nexthop_outb), 32'(eb));
        check({name, "_valid"}, 32'(nexthop_valid), 32'(ev));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 3'd0, 3'd0, 9'd0,  9'd8,  1'b1};
        vecs[1] = '{1'b0, 3'd7, 3'd7, 9'd7,  9'd15, 1'b1};
        vecs[2] = '{1'b1, 3'd2, 3'd5, 9'd18, 9'd29, 1'b1};
        vecs[3] = '{1'b1, 3'd0, 3'd7, 9'd16, 9'd31, 1'b1};
        vecs[4] = '{1'b0, 3'd3, 3'd1, 9'd3,  9'd9,  1'b1};
        vecs[5] = '{1'b1, 3'd7, 3'd0, 9'd23, 9'd24, 1'b1};

        reset               = 1'b1;
        enable              = 1'b1;
        ram_config_in       = '0;
        ram_config_in_valid = 1'b0;
        reload_req          = 1'b0;
        reload_ctx          = '0;
        ctx_sel             = '0;
        lookup_valid        = 1'b0;
        dest_ina            = '0;
        dest_inb            = '0;
        repeat (2) tick();
        reset = 1'b0;

        check("rst_outa", 32'(nexthop_outa), 32'd0);
        check("rst_outb", 32'(nexthop_outb), 32'd0);
        check("rst_valid", 32'(nexthop_valid), 32'd0);
        check("rst_busy", 32'(reload_busy), 32'd1);
        check("rst_cfg_valid", 32'(ram_config_out_valid), 32'd0);

        // Partial load then reset: progress must be discarded.
        for (int i = 0; i < 10; i++) send_word(16'h100 + 16'(i));
        do_lookup(1'b0, 3'd3, 3'd0);
        check("partial_outa", 32'(nexthop_outa), 32'h103);
        check("partial_valid", 32'(nexthop_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_outa", 32'(nexthop_outa), 32'd0);
        check("midrst_outb", 32'(nexthop_outb), 32'd0);
        check("midrst_valid", 32'(nexthop_valid), 32'd0);
        check("midrst_busy", 32'(reload_busy), 32'd1);

        // Full load, value = index, with validity checks at the context boundary.
        for (int i = 0; i < 15; i++) send_word(16'(i));
        do_lookup(1'b0, 3'd2, 3'd5);
        check("early_valid", 32'(nexthop_valid), 32'd0);
        send_word(16'd15);
        check("ctx0_done_busy", 32'(reload_busy), 32'd1);
        check_lookup("ctx0_only", 1'b0, 3'd2, 3'd5, 9'd2, 9'd13, 1'b1);
        do_lookup(1'b1, 3'd2, 3'd5);
        check("ctx1_notyet_valid", 32'(nexthop_valid), 32'd0);
        for (int i = 16; i < 31; i++) send_word(16'(i));
        check("word30_busy", 32'(reload_busy), 32'd1);
        send_word(16'd31);
        check("word31_busy", 32'(reload_busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            check_lookup($sformatf("vec%0d", i), vecs[i].ctx, vecs[i].a, vecs[i].b,
                         vecs[i].ea, vecs[i].eb, vecs[i].ev);
        end

        // Passthrough in PASS: forwarded unchanged, table untouched.
        begin
            logic [15:0] words [3];
            words[0] = 16'h01AB;
            words[1] = 16'h00C0;
            words[2] = 16'h0055;
            for (int k = 0; k < 3; k++) begin
                ram_config_in       = words[k];
                ram_config_in_valid = 1'b1;
                #1;
                check($sformatf("pass_data%0d", k), 32'(ram_config_out), 32'(words[k]));
                check($sformatf("pass_valid%0d", k), 32'(ram_config_out_valid), 32'd1);
                tick();
                ram_config_in_valid = 1'b0;
            end
        end
        check("pass_busy", 32'(reload_busy), 32'd0);
        check_lookup("pass_ctx0", 1'b0, 3'd0, 3'd0, 9'd0, 9'd8, 1'b1);
        check_lookup("pass_ctx1", 1'b1, 3'd2, 3'd5, 9'd18, 9'd29, 1'b1);

        // Reload context 0; the word arriving with the request is forwarded.
        reload_ctx          = 1'b0;
        reload_req          = 1'b1;
        ram_config_in       = 16'h00AA;
        ram_config_in_valid = 1'b1;
        #1;
        check("req_word_fwd", 32'(ram_config_out_valid), 32'd1);
        tick();
        reload_req          = 1'b0;
        ram_config_in_valid = 1'b0;
        check("reload_busy", 32'(reload_busy), 32'd1);
        for (int i = 0; i < 7; i++) send_word(16'h0100);

        // Write index 7 while looking it up: old contents come back.
        ram_config_in       = 16'h0100;
        ram_config_in_valid = 1'b1;
        ctx_sel             = 1'b0;
        dest_ina            = 3'd7;
        dest_inb            = 3'd0;
        lookup_valid        = 1'b1;
        #1;
        check("reload_no_fwd", 32'(ram_config_out_valid), 32'd0);
        tick();
        ram_config_in_valid = 1'b0;
        lookup_valid        = 1'b0;
        repeat (LAT - 1) tick();
        check("rbw_outa", 32'(nexthop_outa), 32'd7);
        check("rbw_outb", 32'(nexthop_outb), 32'd8);
        check("reload_ctx0_valid", 32'(nexthop_valid), 32'd0);
        check_lookup("reload_ctx1", 1'b1, 3'd2, 3'd5, 9'd18, 9'd29, 1'b1);

        // A request during RELOAD must be dropped.
        reload_ctx = 1'b1;
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        for (int i = 8; i < 15; i++) send_word(16'h0100);
        check("reload_word14_busy", 32'(reload_busy), 32'd1);
        send_word(16'h0100);
        check("reload_done_busy", 32'(reload_busy), 32'd0);
        check_lookup("after_ctx0", 1'b0, 3'd2, 3'd5, 9'h100, 9'h100, 1'b1);
        check_lookup("after_ctx1", 1'b1, 3'd2, 3'd5, 9'd18, 9'd29, 1'b1);
        check("no_queued_reload", 32'(reload_busy), 32'd0);

        // Enable low holds the result while new lookups are presented.
        do_lookup(1'b1, 3'd2, 3'd5);
        enable       = 1'b0;
        ctx_sel      = 1'b0;
        dest_ina     = 3'd1;
        dest_inb     = 3'd1;
        lookup_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_outa", i), 32'(nexthop_outa), 32'd18);
            check($sformatf("hold%0d_outb", i), 32'(nexthop_outb), 32'd29);
            check($sformatf("hold%0d_valid", i), 32'(nexthop_valid), 32'd1);
        end
        lookup_valid = 1'b0;
        enable       = 1'b1;
        check_lookup("resume", 1'b0, 3'd1, 3'd1, 9'h100, 9'h100, 1'b1);
        check_lookup("resume_ctx1", 1'b1, 3'd6, 3'd6, 9'd22, 9'd30, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/routing_table_ctx.md
ROUTING_TABLE_CTX -- requirements
Module: routing_table_ctx

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, lookup address width per port.
REQ-002 SHALL have parameter NH_WIDTH, default 9, next-hop width, legal range 1..16.
REQ-003 SHALL have parameter NUM_CTX, default 2, number of table contexts (power of two, >=1).
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  lookup pipeline advance; when low, lookup outputs and valids hold.
REQ-007 ram_config_in  in  16  configuration word stream.
REQ-008 ram_config_in_valid  in  1  qualifies ram_config_in.
REQ-009 ram_config_out  out  16  combinational copy of ram_config_in.
REQ-010 ram_config_out_valid  out  1  ram_config_in_valid gated by state==PASS.
REQ-011 reload_req  in  1  request to rewrite one context; sampled only in PASS.
REQ-012 reload_ctx  in  log2(NUM_CTX) (min 1)  context to rewrite.
REQ-013 reload_busy  out  1  high in LOAD and RELOAD.
REQ-014 ctx_sel  in  log2(NUM_CTX) (min 1)  context used by both lookup ports.
REQ-015 lookup_valid  in  1  qualifies dest_ina/dest_inb.
REQ-016 dest_ina, dest_inb  in  ADDR_WIDTH  lookup addresses, port A and port B.
REQ-017 nexthop_outa, nexthop_outb  out  NH_WIDTH  lookup results.
REQ-018 nexthop_valid  out  1  result qualifier, low if looked-up context was not fully written.

Function
REQ-019 Each context SHALL hold 2*2^ADDR_WIDTH entries: lower half read by port A, upper half by port B.
REQ-020 Storage word index SHALL be {ctx, half, addr}; config word stored = ram_config_in[NH_WIDTH-1:0].
REQ-021 FSM states SHALL be LOAD, PASS, RELOAD; reset enters LOAD with word counter 0.
REQ-022 In LOAD each valid word SHALL be written at counter index then counter incremented; counter width log2(NUM_CTX)+ADDR_WIDTH+2 bits.
REQ-023 After word NUM_CTX*2^(ADDR_WIDTH+1)-1 is written, state SHALL go to PASS next cycle; no further word is consumed in LOAD.
REQ-024 In PASS, reload_req=1 SHALL latch reload_ctx, clear ctx_ok[reload_ctx], zero an in-context counter and enter RELOAD; words arriving the same cycle are forwarded, not consumed.
REQ-025 In RELOAD each valid word SHALL be written to {reload_ctx, counter} and not forwarded; after 2^(ADDR_WIDTH+1) words set ctx_ok[reload_ctx] and return to PASS.
REQ-026 reload_req outside PASS SHALL be ignored (no queueing).
REQ-027 Per-context ctx_ok SHALL be set when that context's last word is written in LOAD or RELOAD.
REQ-028 Lookup latency SHALL be 1 cycle: lookup_valid&enable at cycle N gives nexthop_valid=lookup_valid&ctx_ok[ctx_sel] at N+1.
REQ-029 A lookup hitting the entry written the same cycle SHALL return the old value (read-before-write).
REQ-030 Lookups SHALL proceed in every state; ports A and B never stall each other.

Reset
REQ-031 Reset SHALL clear state to LOAD, all counters, all ctx_ok, nexthop_valid, nexthop_outa/outb (0); table contents undefined.
REQ-032 Reset mid-LOAD or mid-RELOAD SHALL discard progress; full reload required.

Configuration
REQ-033 Macro RT_OUT_REG_EN defined: extra output register stage, latency 2, enable holds both stages.
REQ-034 Macro undefined: latency 1 per REQ-028, no extra stage.

Structure
REQ-035 Shared package SHALL hold FSM state enum (LOAD, PASS, RELOAD) and a clog2 function.
REQ-036 One sub-module rt_dp_ram (one write port, two read ports, parameter WIDTH/LOG_DEP) holds storage.

Verification (ADDR_WIDTH=3, NH_WIDTH=9, NUM_CTX=2; 16 words/ctx, 32 total)
REQ-037 Load words 0..31 with value=index -> reload_busy falls after word 31; ctx_sel=1, dest_ina=2, dest_inb=5 -> outa=18, outb=29, valid=1 one cycle later.
REQ-038 After load, send 3 words 0x1AB,0x0C0,0x055 -> ram_config_out_valid high 3 cycles, data unchanged; table unchanged.
REQ-039 Lookup before load completes -> nexthop_valid=0; after word 15 only, ctx_sel=0 valid=1, ctx_sel=1 valid=0.
REQ-040 reload_req ctx=0, write 16 words of 0x100 -> ctx0 lookups valid=0 during, then 0x100; ctx1 unchanged and valid throughout.
REQ-041 Reset asserted after 10 load words -> outputs 0, counter 0; 32 new words load correctly from index 0.
REQ-042 With RT_OUT_REG_EN: result at N+2; enable low 3 cycles -> outputs held, resume unchanged.
